// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: one outstanding imem request, DEPTH-entry {pc, ins} queue toward IDU.
// Optional perf counters are compiled in when IFU_PERF_CNT_EN is defined.
module ifu_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_ins,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // imem responses carry no ready and are always accepted.

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]   pc_mem  [DEPTH];
    logic [INST_W-1:0] ins_mem [DEPTH];

    logic req_hs;
    logic push;
    logic pop;

    assign req_hs = imem_req_valid && imem_req_ready;
    // Redirect wins over both queue ports in the same cycle.
    assign push   = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop    = out_valid && out_ready && !redirect_valid;

    assign imem_req_addr = fetch_pc_q;
    assign out_valid     = !rst && (count_q != '0);
    assign out_pc        = pc_mem[rd_ptr_q];
    assign out_ins       = ins_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (req_hs) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid)      state_d = S_REQ;
                else if (redirect_valid) state_d = S_DROP;
            end
            S_DROP:  if (imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // A request only goes out when a queue slot is free, so the later push never overflows.
    always_comb begin
        imem_req_valid = 1'b0;
        dbg_state_o    = state_q;
        if (!rst && (state_q == S_REQ) && (count_q < FULL_C) && !redirect_valid) begin
            imem_req_valid = 1'b1;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            ins_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pop)            perf_fetch_q <= perf_fetch_q + 32'd1;
            if (redirect_valid) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // Counters compiled out: no extra ports or state.
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: memory model plus scoreboard of expected request addresses and outputs.
// Define IFU_PERF_CNT_EN to also check the perf counters.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic [1:0]  dbg_state;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  ifu_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ins        (out_ins),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .dbg_state_o    (dbg_state)
  );

  // clock / reset: posedge at 5+10k, negedge at 10k; driver at negedge+1,
  // memory model at negedge+2, monitor and direct checks at negedge+3.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_req_q[$];
  int hs_cyc_q[$];
  int pop_cyc_q[$];
  int budget = 0;
  int lat = 1;
  int hs_cnt = 0;
  int pops = 0;
  logic m_pend = 1'b0;
  int m_cnt = 0;
  logic [31:0] m_addr = '0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_req_q.push_back(pc);
    exp_q.push_back({pc, mem_f(pc)});
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 60 && hs_cnt < target; i++) tick();
    check("wait_hs", 64'(hs_cnt >= target), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && exp_req_q.size() == 0) break;
      tick();
    end
    check("drain", 64'(exp_q.size() + exp_req_q.size()), 64'd0);
    repeat (4) tick();
  endtask

  // memory model: accepts while budget>0, answers after lat cycles, checks request addresses
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        m_pend         = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
        if (m_pend) begin
          if (m_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_f(m_addr);
            m_pend         = 1'b0;
          end else begin
            m_cnt--;
          end
        end
        imem_req_ready = (budget > 0);
        if (imem_req_valid && imem_req_ready) begin
          check("single_outstanding", 64'(m_pend), 64'd0);
          budget--;
          hs_cnt++;
          hs_cyc_q.push_back(cyc);
          m_pend = 1'b1;
          m_addr = imem_req_addr;
          m_cnt  = lat - 1;
          if (exp_req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected actual=%0h required=none", imem_req_addr);
          end else begin
            check("req_addr", 64'(imem_req_addr), 64'(exp_req_q.pop_front()));
          end
        end
      end
    end
  end

  // monitor: pops the expected queue on every out handshake
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid && out_ready && !redirect_valid) begin
        pops++;
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h required=none", {out_pc, out_ins});
        end else begin
          check("out_pc_ins", {out_pc, out_ins}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int base;
    int p0;
    int d_lat;
    int d_thr;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    repeat (3) tick();
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    rst = 1'b0;

    // sequential fetch, memory answers one cycle later, IDU always ready
    out_ready = 1'b1;
    hs_cyc_q.delete();
    pop_cyc_q.delete();
    exp_push(32'h8000_0000);
    exp_push(32'h8000_0004);
    exp_push(32'h8000_0008);
    budget = 3;
    wait_drain();
    check("t1_pop_count", 64'(pop_cyc_q.size()), 64'd3);
    d_lat = (pop_cyc_q.size() >= 3 && hs_cyc_q.size() >= 1) ? pop_cyc_q[0] - hs_cyc_q[0] : -1;
    d_thr = (pop_cyc_q.size() >= 3) ? pop_cyc_q[2] - pop_cyc_q[0] : -1;
    check("t1_first_latency", 64'(d_lat), 64'd2);
    check("t1_throughput", 64'(d_thr), 64'd4);

    // IDU stalled: only DEPTH requests may go out
    out_ready = 1'b0;
    base = hs_cnt;
    exp_push(32'h8000_000C);
    exp_push(32'h8000_0010);
    exp_push(32'h8000_0014);
    exp_push(32'h8000_0018);
    exp_push(32'h8000_001C);
    budget = 5;
    repeat (12) tick();
    #2;
    check("t2_hs_count", 64'(hs_cnt - base), 64'd2);
    check("t2_req_valid_held", 64'(imem_req_valid), 64'd0);
    check("t2_out_valid", 64'(out_valid), 64'd1);
    tick();
    p0 = pops;
    out_ready = 1'b1;
    wait_drain();
    check("t2_pops", 64'(pops - p0), 64'd5);

    // redirect while waiting; the late response must be dropped
    lat = 3;
    exp_req_q.push_back(32'h8000_0020);
    base = hs_cnt;
    budget = 1;
    wait_hs(base + 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1002;
    lat = 1;
    exp_push(32'h8000_1000);
    exp_push(32'h8000_1004);
    budget = 2;
    tick();
    redirect_valid = 1'b0;
    #2;
    check("t3_drop_req_valid", 64'(imem_req_valid), 64'd0);
    check("t3_queue_empty", 64'(out_valid), 64'd0);
    wait_drain();

    // redirect together with a response and an out handshake
    out_ready = 1'b0;
    exp_req_q.push_back(32'h8000_1008);
    exp_req_q.push_back(32'h8000_100C);
    base = hs_cnt;
    budget = 2;
    wait_hs(base + 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    out_ready      = 1'b1;
    exp_push(32'h8000_2000);
    budget = 1;
    tick();
    redirect_valid = 1'b0;
    #2;
    check("t4_flush_empty", 64'(out_valid), 64'd0);
    wait_drain();

    // redirect near the top of the address space; PC wraps
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    exp_push(32'hFFFF_FFFC);
    exp_push(32'h0000_0000);
    budget = 2;
    #2;
    check("t5_redirect_forces_req_low", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    wait_drain();

`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", 64'(perf_fetch_cnt), 64'd13);
    check("perf_flush", 64'(perf_flush_cnt), 64'd3);
`endif

    // reset during an in-flight request
    lat = 3;
    exp_req_q.push_back(32'h0000_0004);
    base = hs_cnt;
    budget = 1;
    wait_hs(base + 1);
    rst = 1'b1;
    tick();
    tick();
    #2;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch_rst", 64'(perf_fetch_cnt), 64'd0);
    check("perf_flush_rst", 64'(perf_flush_cnt), 64'd0);
`endif
    tick();
    rst = 1'b0;
    lat = 1;
    exp_push(32'h8000_0000);
    budget = 1;
    wait_drain();
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch_after", 64'(perf_fetch_cnt), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
